// File: rtl/mc_store_arbiter_pkg.sv
// Shared types for the store-side memory controller.
// FSM encodings and the one-hot encoder used by the arbiters.
package mc_store_arbiter_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } stateT;

  localparam int MAX_PORTS = 32;

  function automatic int unsigned onehotToIdx(
    input logic [MAX_PORTS-1:0] oh
  );
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mc_store_arbiter_if.sv
// Store-port, ctrl and memory-side bundle of the store arbiter.
// master = environment side, slave = arbiter side.
interface mc_store_arbiter_if #(
  parameter int NUM_STORES = 2,
  parameter int DATA_TYPE  = 32,
  parameter int ADDR_TYPE  = 32,
  parameter int CTRL_TYPE  = 32
);
  import mc_store_arbiter_pkg::*;

  logic [NUM_STORES*ADDR_TYPE-1:0] ins_addr;
  logic [NUM_STORES*DATA_TYPE-1:0] ins_data;
  logic [NUM_STORES-1:0]           ins_valid;
  logic [NUM_STORES-1:0]           ins_ready;
  logic [CTRL_TYPE-1:0]            ctrl;
  logic                            ctrl_valid;
  logic                            ctrl_ready;
  logic                            ctrlEnd_valid;
  logic                            ctrlEnd_ready;
  logic                            storeEn;
  logic [ADDR_TYPE-1:0]            storeAddr;
  logic [DATA_TYPE-1:0]            storeData;
  logic                            memEnd_valid;
  logic                            memEnd_ready;

  modport master (
    output ins_addr, ins_data, ins_valid,
    output ctrl, ctrl_valid, ctrlEnd_valid,
    output memEnd_ready,
    input  ins_ready, ctrl_ready, ctrlEnd_ready,
    input  storeEn, storeAddr, storeData,
    input  memEnd_valid
  );

  modport slave (
    input  ins_addr, ins_data, ins_valid,
    input  ctrl, ctrl_valid, ctrlEnd_valid,
    input  memEnd_ready,
    output ins_ready, ctrl_ready, ctrlEnd_ready,
    output storeEn, storeAddr, storeData,
    output memEnd_valid
  );

endinterface

// File: rtl/mc_store_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first request strictly after ptr, wrapping.
module rr_arbiter
  import mc_store_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grantIdx
);

  // scan far-to-near so the nearest request after ptr wins
  always_comb begin
    grant = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[IW'((int'(ptr) + k) % N)]) begin
        grant = '0;
        grant[IW'((int'(ptr) + k) % N)] = 1'b1;
      end
    end
  end

  assign grantIdx = IW'(onehotToIdx(MAX_PORTS'(grant)));

endmodule

// File: rtl/mc_store_arbiter.sv
// Store arbiter: shares one memory write port between store ports
// and signals memEnd once all announced stores are issued.
module mc_store_arbiter
  import mc_store_arbiter_pkg::*;
#(
  parameter int NUM_STORES = 2,
  parameter int DATA_TYPE  = 32,
  parameter int ADDR_TYPE  = 32,
  parameter int CTRL_TYPE  = 32
) (
  input logic clk,
  input logic rst,
  mc_store_arbiter_if.slave bus
);

  localparam int IW = (NUM_STORES > 1) ? $clog2(NUM_STORES) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_STORES - 1);

  stateT                 state;
  logic [CTRL_TYPE-1:0]  pending;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         grantIdx;
  logic [NUM_STORES-1:0] eligible;
  logic [NUM_STORES-1:0] grant;
  logic                  grantAny;
  logic                  runState;
  logic                  ctrlFire;
  logic                  endFire;
  logic                  storeEnQ;
  logic [ADDR_TYPE-1:0]  storeAddrQ;
  logic [DATA_TYPE-1:0]  storeDataQ;
  logic                  memEndQ;

  assign runState = (state == RUN);
  assign eligible = bus.ins_valid &
    {NUM_STORES{(pending != '0) && (state != DONE)}};

  rr_arbiter #(
    .N  (NUM_STORES),
    .IW (IW)
  ) uArb (
    .req      (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  assign grantAny = |grant;
  assign ctrlFire = bus.ctrl_valid & runState;
  assign endFire  = bus.ctrlEnd_valid & runState;

  assign bus.ins_ready     = grant;
  assign bus.ctrl_ready    = runState;
  assign bus.ctrlEnd_ready = runState;
  assign bus.storeEn       = storeEnQ;
  assign bus.storeAddr     = storeAddrQ;
  assign bus.storeData     = storeDataQ;
  assign bus.memEnd_valid  = memEndQ;

  // register the granted token onto the memory port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      storeEnQ   <= 1'b0;
      storeAddrQ <= '0;
      storeDataQ <= '0;
    end else begin
      storeEnQ <= grantAny;
      if (grantAny) begin
        storeAddrQ <=
          bus.ins_addr[int'(grantIdx)*ADDR_TYPE +: ADDR_TYPE];
        storeDataQ <=
          bus.ins_data[int'(grantIdx)*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  // pending store count and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      ptr     <= PTR_RST;
    end else begin
      pending <= pending
               + (ctrlFire ? bus.ctrl : '0)
               - CTRL_TYPE'(grantAny);
      if (grantAny) ptr <= grantIdx;
    end
  end

  // end-of-control FSM; pending==0 in DRAIN means no grant now,
  // so the final write leaves the register on this same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      memEndQ <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (endFire) state <= DRAIN;
        end
        DRAIN: begin
          if (pending == '0) begin
            state   <= DONE;
            memEndQ <= 1'b1;
          end
        end
        DONE: begin
          if (bus.memEnd_ready) begin
            state   <= RUN;
            memEndQ <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          memEndQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_store_arbiter.sv
// Bench for mc_store_arbiter: directed table, corner sequences,
// and random traffic against a behavioural model.
module tb_mc_store_arbiter;
  import mc_store_arbiter_pkg::*;

  localparam int N = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mc_store_arbiter_if #(
    .NUM_STORES(N), .DATA_TYPE(32),
    .ADDR_TYPE(32), .CTRL_TYPE(32)
  ) bus ();

  mc_store_arbiter #(
    .NUM_STORES(N), .DATA_TYPE(32),
    .ADDR_TYPE(32), .CTRL_TYPE(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  valid;
    logic        cv;
    logic [31:0] c;
    logic [2:0]  expRdy;
    logic        expEn;
    int          src;
  } vecT;

  logic [31:0] ia [N];
  logic [31:0] id [N];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic packIns();
    bus.ins_addr = {ia[2], ia[1], ia[0]};
    bus.ins_data = {id[2], id[1], id[0]};
  endtask

  task automatic clearIns();
    bus.ins_valid     = '0;
    bus.ctrl          = '0;
    bus.ctrl_valid    = 1'b0;
    bus.ctrlEnd_valid = 1'b0;
    bus.memEnd_ready  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearIns();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // behavioural model state
  longint      mPend;
  int          mPtr;
  int          mPh;
  logic        mEn;
  logic [31:0] mAddr;
  logic [31:0] mData;

  task automatic modelCycle();
    int g;
    logic [2:0] expR;
    g = -1;
    if (mPend > 0 && mPh != 2) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && bus.ins_valid[(mPtr + k) % N]) g = (mPtr + k) % N;
      end
    end
    expR = (g >= 0) ? 3'(1 << g) : 3'd0;
    chk("rnd ins_ready", 64'(bus.ins_ready), 64'(expR));
    chk("rnd ctrl_ready", 64'(bus.ctrl_ready), 64'(mPh == 0));
    chk("rnd ctrlEnd_ready", 64'(bus.ctrlEnd_ready), 64'(mPh == 0));
    chk("rnd storeEn", 64'(bus.storeEn), 64'(mEn));
    chk("rnd storeAddr", 64'(bus.storeAddr), 64'(mAddr));
    chk("rnd storeData", 64'(bus.storeData), 64'(mData));
    chk("rnd memEnd_valid", 64'(bus.memEnd_valid), 64'(mPh == 2));
    // next state
    case (mPh)
      0: if (bus.ctrlEnd_valid) mPh = 1;
      1: if (mPend == 0) mPh = 2;
      default: if (bus.memEnd_ready) mPh = 0;
    endcase
    if (bus.ctrl_valid && expR == 0 && mPh != 1 && mPh != 2) begin
    end
    if (g >= 0) begin
      mEn   = 1'b1;
      mAddr = ia[g];
      mData = id[g];
      mPtr  = g;
      mPend = mPend - 1;
    end else begin
      mEn = 1'b0;
    end
  endtask

  vecT tbl [9];

  initial begin
    // ---------- 1: reset with all inputs active ----------
    rst = 1'b0;
    bus.ins_valid     = '1;
    bus.ins_addr      = '1;
    bus.ins_data      = '1;
    bus.ctrl          = '1;
    bus.ctrl_valid    = 1'b1;
    bus.ctrlEnd_valid = 1'b1;
    bus.memEnd_ready  = 1'b1;
    tick();
    tick();
    chk("t1 storeEn", 64'(bus.storeEn), 64'd0);
    chk("t1 memEnd_valid", 64'(bus.memEnd_valid), 64'd0);
    chk("t1 ins_ready", 64'(bus.ins_ready), 64'd0);
    clearIns();
    rst = 1'b1;
    bus.ctrl = 32'd3;
    bus.ctrl_valid = 1'b1;
    #1;
    chk("t1 ctrl_ready", 64'(bus.ctrl_ready), 64'd1);

    // ---------- 2: single requester ----------
    doReset();
    for (int i = 0; i < N; i++) begin ia[i] = '0; id[i] = '0; end
    packIns();
    bus.ctrl = 32'd2;
    bus.ctrl_valid = 1'b1;
    tick();
    bus.ctrl_valid = 1'b0;
    ia[0] = 32'h10; id[0] = 32'hAA; packIns();
    bus.ins_valid = 3'b001;
    #1;
    chk("t2 ready0 a", 64'(bus.ins_ready), 64'd1);
    tick();
    ia[0] = 32'h14; id[0] = 32'hBB; packIns();
    #1;
    chk("t2 en a", 64'(bus.storeEn), 64'd1);
    chk("t2 addr a", 64'(bus.storeAddr), 64'h10);
    chk("t2 data a", 64'(bus.storeData), 64'hAA);
    chk("t2 ready0 b", 64'(bus.ins_ready), 64'd1);
    tick();
    bus.ins_valid = '0;
    #1;
    chk("t2 en b", 64'(bus.storeEn), 64'd1);
    chk("t2 addr b", 64'(bus.storeAddr), 64'h14);
    chk("t2 data b", 64'(bus.storeData), 64'hBB);
    tick();
    chk("t2 en off", 64'(bus.storeEn), 64'd0);
    chk("t2 addr hold", 64'(bus.storeAddr), 64'h14);

    // ---------- 3: fairness table ----------
    tbl[0] = '{3'b111, 1'b1, 32'd6, 3'b000, 1'b0, 0};
    tbl[1] = '{3'b111, 1'b0, 32'd0, 3'b001, 1'b0, 0};
    tbl[2] = '{3'b111, 1'b0, 32'd0, 3'b010, 1'b1, 0};
    tbl[3] = '{3'b111, 1'b0, 32'd0, 3'b100, 1'b1, 1};
    tbl[4] = '{3'b111, 1'b0, 32'd0, 3'b001, 1'b1, 2};
    tbl[5] = '{3'b111, 1'b0, 32'd0, 3'b010, 1'b1, 0};
    tbl[6] = '{3'b111, 1'b0, 32'd0, 3'b100, 1'b1, 1};
    tbl[7] = '{3'b111, 1'b0, 32'd0, 3'b000, 1'b1, 2};
    tbl[8] = '{3'b111, 1'b0, 32'd0, 3'b000, 1'b0, 0};
    doReset();
    for (int i = 0; i < N; i++) begin
      ia[i] = 32'h100 + 32'(4 * i);
      id[i] = 32'hD0 + 32'(i);
    end
    packIns();
    for (int r = 0; r < 9; r++) begin
      bus.ins_valid  = tbl[r].valid;
      bus.ctrl_valid = tbl[r].cv;
      bus.ctrl       = tbl[r].c;
      #1;
      chk($sformatf("t3 row%0d ready", r),
          64'(bus.ins_ready), 64'(tbl[r].expRdy));
      chk($sformatf("t3 row%0d en", r),
          64'(bus.storeEn), 64'(tbl[r].expEn));
      if (tbl[r].expEn)
        chk($sformatf("t3 row%0d addr", r), 64'(bus.storeAddr),
            64'(32'h100 + 32'(4 * tbl[r].src)));
      tick();
    end

    // ---------- 4: ctrl and grant in one cycle ----------
    doReset();
    bus.ctrl = 32'd1;
    bus.ctrl_valid = 1'b1;
    tick();
    bus.ctrl = 32'd4;
    bus.ins_valid = 3'b001;
    #1;
    chk("t4 grant", 64'(bus.ins_ready), 64'd1);
    tick();
    clearIns();
    #1;
    chk("t4 pending", 64'(dut.pending), 64'd4);

    // ---------- 5: end of control ----------
    doReset();
    bus.ctrl = 32'd2;
    bus.ctrl_valid = 1'b1;
    bus.ctrlEnd_valid = 1'b1;
    #1;
    chk("t5 ctrlEnd_ready", 64'(bus.ctrlEnd_ready), 64'd1);
    tick();
    bus.ctrl_valid = 1'b0;
    bus.ctrlEnd_valid = 1'b0;
    ia[0] = 32'h20; packIns();
    bus.ins_valid = 3'b001;
    #1;
    chk("t5 drain ctrl_ready", 64'(bus.ctrl_ready), 64'd0);
    chk("t5 drain end_ready", 64'(bus.ctrlEnd_ready), 64'd0);
    chk("t5 grant a", 64'(bus.ins_ready), 64'd1);
    tick();
    ia[0] = 32'h24; packIns();
    #1;
    chk("t5 en a", 64'(bus.storeEn), 64'd1);
    chk("t5 grant b", 64'(bus.ins_ready), 64'd1);
    tick();
    #1;
    chk("t5 en b", 64'(bus.storeEn), 64'd1);
    chk("t5 addr b", 64'(bus.storeAddr), 64'h24);
    chk("t5 memEnd early", 64'(bus.memEnd_valid), 64'd0);
    tick();
    chk("t5 memEnd rise", 64'(bus.memEnd_valid), 64'd1);
    chk("t5 en off", 64'(bus.storeEn), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 hold%0d", i), 64'(bus.memEnd_valid), 64'd1);
      chk($sformatf("t5 nogrant%0d", i), 64'(bus.ins_ready), 64'd0);
    end
    bus.memEnd_ready = 1'b1;
    tick();
    bus.memEnd_ready = 1'b0;
    bus.ins_valid = '0;
    #1;
    chk("t5 memEnd fall", 64'(bus.memEnd_valid), 64'd0);
    chk("t5 run ctrl_ready", 64'(bus.ctrl_ready), 64'd1);
    chk("t5 state", 64'(dut.state), 64'(RUN));

    // ---------- 6: reset mid-write ----------
    doReset();
    bus.ctrl = 32'd3;
    bus.ctrl_valid = 1'b1;
    tick();
    bus.ctrl_valid = 1'b0;
    bus.ins_valid = 3'b001;
    tick();
    chk("t6 en before", 64'(bus.storeEn), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6 en", 64'(bus.storeEn), 64'd0);
    chk("t6 pending", 64'(dut.pending), 64'd0);
    chk("t6 state", 64'(dut.state), 64'(RUN));
    chk("t6 memEnd", 64'(bus.memEnd_valid), 64'd0);
    clearIns();
    tick();
    rst = 1'b1;

    // ---------- random traffic vs model ----------
    doReset();
    mPend = 0; mPtr = N - 1; mPh = 0;
    mEn = 1'b0; mAddr = '0; mData = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        ia[i] = $urandom;
        id[i] = $urandom;
      end
      packIns();
      bus.ins_valid     = 3'($urandom_range(0, 7));
      bus.ctrl_valid    = ($urandom_range(0, 3) == 0);
      bus.ctrl          = 32'($urandom_range(0, 3));
      bus.ctrlEnd_valid = ($urandom_range(0, 19) == 0);
      bus.memEnd_ready  = ($urandom_range(0, 2) == 0);
      #1;
      if (bus.ctrl_valid && mPh == 0) begin
        assert (mPend + longint'(bus.ctrl) < 64'h1_0000_0000)
          else $error("ctrl overflows pending");
      end
      begin
        longint add;
        add = (bus.ctrl_valid && mPh == 0) ? longint'(bus.ctrl) : 0;
        modelCycle();
        mPend = mPend + add;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
